// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// get_field pulls lane k (width w) out of a packed per-port vector.
package regfile_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_NUM_RD  = 2;
  localparam int ZERO_REG    = 0;

  // Widest packed port vector / field the helper handles (4 x 64 bits).
  localparam int FIELD_VEC_W = 256;
  localparam int FIELD_MAX_W = 64;

  function automatic logic [FIELD_MAX_W-1:0] get_field(
    input logic [FIELD_VEC_W-1:0] vec,
    input int                     k,
    input int                     w
  );
    logic [FIELD_VEC_W-1:0] shifted;
    logic [FIELD_VEC_W-1:0] mask;
    shifted = vec >> (k * w);
    mask    = (FIELD_VEC_W'(1) << w) - FIELD_VEC_W'(1);
    return FIELD_MAX_W'(shifted & mask);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: a mark sets, a write clears, mark wins a same-cycle collision.
// Register 0 is never busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mark_en,
  input  logic [ADDR_W-1:0]     mark_addr,
  input  logic [1:0]            wr_en,
  input  logic [2*ADDR_W-1:0]   wr_addr,
  output logic [(2**ADDR_W)-1:0] busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W-1:0] wa0;
  logic [ADDR_W-1:0] wa1;

  assign wa0 = wr_addr[0 +: ADDR_W];
  assign wa1 = wr_addr[ADDR_W +: ADDR_W];

  always_comb begin
    logic set_i;
    logic clr_i;
    busy_nxt = busy_q;
    set_i    = 1'b0;
    clr_i    = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      set_i = mark_en && (mark_addr == ADDR_W'(i));
      clr_i = (wr_en[0] && (wa0 == ADDR_W'(i))) ||
              (wr_en[1] && (wa1 == ADDR_W'(i)));
      busy_nxt[i] = set_i | (busy_q[i] & ~clr_i);
    end
    busy_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write lanes, NUM_RD combinational
// read ports with optional write-to-read bypass, and a pending-write scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic [1:0]               wr_en,
  input  logic [2*ADDR_W-1:0]      wr_addr,
  input  logic [2*DATA_W-1:0]      wr_data,
  input  logic                     mark_en,
  input  logic [ADDR_W-1:0]        mark_addr,
  output logic [(2**ADDR_W)-1:0]   busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  // No handshake anywhere: every input is sampled each cycle and the
  // consumer stalls on rd_ready=0 itself.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wa0;
  logic [ADDR_W-1:0] wa1;
  logic [DATA_W-1:0] wd0;
  logic [DATA_W-1:0] wd1;
  logic              we0;
  logic              we1;
  logic              we0_commit;

  assign wa0 = ADDR_W'(get_field(FIELD_VEC_W'(wr_addr), 0, ADDR_W));
  assign wa1 = ADDR_W'(get_field(FIELD_VEC_W'(wr_addr), 1, ADDR_W));
  assign wd0 = wr_data[0 +: DATA_W];
  assign wd1 = wr_data[DATA_W +: DATA_W];

  assign we0 = wr_en[0] && (wa0 != ZERO_ADDR);
  assign we1 = wr_en[1] && (wa1 != ZERO_ADDR);
  // Lane 1 owns a same-address double write; lane 0 is silently dropped.
  assign we0_commit = we0 && !(we1 && (wa1 == wa0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (we0_commit) begin
        mem[wa0] <= wd0;
      end
      if (we1) begin
        mem[wa1] <= wd1;
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .mark_en   (mark_en),
    .mark_addr (mark_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .busy      (busy)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit0;
    logic              hit1;
    logic [DATA_W-1:0] data;

    assign ra = ADDR_W'(get_field(FIELD_VEC_W'(rd_addr), k, ADDR_W));
    // Bypass is held off during reset so reads show the cleared file.
    assign hit0 = (BYPASS != 0) && rst_n && we0 && (wa0 == ra);
    assign hit1 = (BYPASS != 0) && rst_n && we1 && (wa1 == ra);

    always_comb begin
      data = mem[ra];
      if (ra == ZERO_ADDR) begin
        data = '0;
      end else if (hit1) begin
        data = wd1;
      end else if (hit0) begin
        data = wd0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_ready[k] = ~busy[ra] | hit0 | hit1;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypass and a non-bypass copy share stimulus,
// plus a 4-port 64-bit 16-entry copy for the configuration sweep.
module tb_regfile_mp;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  // Default-geometry inputs, shared by the BYPASS=1 and BYPASS=0 copies.
  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        mark_en;
  logic [4:0]  mark_addr;
  logic [63:0] rd_data,  nb_rd_data;
  logic [1:0]  rd_ready, nb_rd_ready;
  logic [31:0] busy,     nb_busy;

  // Wide configuration.
  logic [15:0]  w_rd_addr;
  logic [1:0]   w_wr_en;
  logic [7:0]   w_wr_addr;
  logic [127:0] w_wr_data;
  logic         w_mark_en;
  logic [3:0]   w_mark_addr;
  logic [255:0] w_rd_data;
  logic [3:0]   w_rd_ready;
  logic [15:0]  w_busy;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_ready(rd_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mark_en(mark_en), .mark_addr(mark_addr), .busy(busy)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(nb_rd_data),
    .rd_ready(nb_rd_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mark_en(mark_en), .mark_addr(mark_addr), .busy(nb_busy)
  );

  regfile_mp #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4), .BYPASS(1)) u_dut_wide (
    .clk(clk), .rst_n(rst_n), .rd_addr(w_rd_addr), .rd_data(w_rd_data),
    .rd_ready(w_rd_ready), .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
    .mark_en(w_mark_en), .mark_addr(w_mark_addr), .busy(w_busy)
  );

  task automatic push_exp(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s no expected value queued, got=%0h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s got=%0h exp=%0h", tag, obs, e);
      end
    end
  endtask

  task automatic idle();
    wr_en   = 2'b00;
    mark_en = 1'b0;
    w_wr_en   = 2'b00;
    w_mark_en = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    idle();
    rd_addr = '0; wr_addr = '0; wr_data = '0; mark_addr = '0;
    w_rd_addr = '0; w_wr_addr = '0; w_wr_data = '0; w_mark_addr = '0;

    // Reset state
    #2;
    push_exp(64'h0); chk("rst_rd0", 64'(rd_data[31:0]));
    push_exp(64'h3); chk("rst_ready", 64'(rd_ready));
    push_exp(64'h0); chk("rst_busy", 64'(busy));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    next_cycle();

    // Reset mid-operation
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
    mark_en = 1'b1; mark_addr = 5'd7;
    next_cycle();
    idle(); rd_addr = {5'd7, 5'd5};
    @(negedge clk);
    push_exp(64'hDEADBEEF); chk("pre_rst_r5", 64'(rd_data[31:0]));
    push_exp(64'h80);       chk("pre_rst_busy", 64'(busy));
    push_exp(64'h1);        chk("pre_rst_ready", 64'(rd_ready));
    #1 rst_n = 1'b0;
    #1;
    push_exp(64'h0); chk("mid_rst_r5", 64'(rd_data[31:0]));
    push_exp(64'h0); chk("mid_rst_r5_nb", 64'(nb_rd_data[31:0]));
    push_exp(64'h0); chk("mid_rst_busy", 64'(busy));
    push_exp(64'h3); chk("mid_rst_ready", 64'(rd_ready));
    #1 rst_n = 1'b1;
    next_cycle();

    // Double write to r3, lane 1 wins
    wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'h22, 32'h11};
    rd_addr = {5'd0, 5'd3};
    @(negedge clk);
    push_exp(64'h22); chk("dbl_bypass", 64'(rd_data[31:0]));
    push_exp(64'h0);  chk("dbl_nb_old", 64'(nb_rd_data[31:0]));
    next_cycle(); idle();
    @(negedge clk);
    push_exp(64'h22); chk("dbl_next", 64'(rd_data[31:0]));
    push_exp(64'h22); chk("dbl_next_nb", 64'(nb_rd_data[31:0]));
    next_cycle();

    // Zero register
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'hFFFFFFFF};
    mark_en = 1'b1; mark_addr = 5'd0; rd_addr = {5'd0, 5'd0};
    @(negedge clk);
    push_exp(64'h0); chk("r0_same", 64'(rd_data[31:0]));
    push_exp(64'h3); chk("r0_ready_same", 64'(rd_ready));
    next_cycle(); idle();
    @(negedge clk);
    push_exp(64'h0); chk("r0_next", 64'(rd_data[31:0]));
    push_exp(64'h0); chk("r0_busy", 64'(busy));
    push_exp(64'h3); chk("r0_ready", 64'(rd_ready));
    next_cycle();

    // Scoreboard: mark r9, stall, then write r9
    mark_en = 1'b1; mark_addr = 5'd9;
    next_cycle(); idle(); rd_addr = {5'd0, 5'd9};
    @(negedge clk);
    push_exp(64'h2); chk("sb_busy_ready", 64'(rd_ready));
    push_exp(64'h2); chk("sb_busy_ready_nb", 64'(nb_rd_ready));
    next_cycle();
    wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h1234, 32'h0};
    @(negedge clk);
    push_exp(64'h1);    chk("sb_wr_ready", 64'(rd_ready[0]));
    push_exp(64'h1234); chk("sb_wr_data", 64'(rd_data[31:0]));
    push_exp(64'h0);    chk("sb_wr_ready_nb", 64'(nb_rd_ready[0]));
    push_exp(64'h0);    chk("sb_wr_data_nb", 64'(nb_rd_data[31:0]));
    next_cycle(); idle();
    @(negedge clk);
    push_exp(64'h1);    chk("sb_after_ready_nb", 64'(nb_rd_ready[0]));
    push_exp(64'h1234); chk("sb_after_data_nb", 64'(nb_rd_data[31:0]));
    push_exp(64'h0);    chk("sb_after_busy", 64'(busy));
    next_cycle();

    // Mark/write collision on r4
    mark_en = 1'b1; mark_addr = 5'd4;
    next_cycle();
    mark_en = 1'b1; mark_addr = 5'd4;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h55};
    next_cycle(); idle(); rd_addr = {5'd4, 5'd0};
    @(negedge clk);
    push_exp(64'h55); chk("coll_data", 64'(rd_data[63:32]));
    push_exp(64'h10); chk("coll_busy", 64'(busy));
    push_exp(64'h1);  chk("coll_ready", 64'(rd_ready));
    next_cycle();
    wr_en = 2'b10; wr_addr = {5'd4, 5'd0}; wr_data = {32'h66, 32'h0};
    next_cycle(); idle();
    @(negedge clk);
    push_exp(64'h0);  chk("coll_clear_busy", 64'(busy));
    push_exp(64'h66); chk("coll_clear_data", 64'(nb_rd_data[63:32]));
    next_cycle();

    // Two lanes to distinct registers
    wr_en = 2'b11; wr_addr = {5'd11, 5'd10}; wr_data = {32'hBBBB0011, 32'hAAAA0010};
    next_cycle(); idle(); rd_addr = {5'd11, 5'd10};
    @(negedge clk);
    push_exp(64'hAAAA0010); chk("dual_p0", 64'(rd_data[31:0]));
    push_exp(64'hBBBB0011); chk("dual_p1", 64'(rd_data[63:32]));
    next_cycle();

    // Random data to fresh registers r16..r19 via lane 0, read on port 1
    for (int i = 0; i < 4; i++) begin
      d = $urandom_range(32'hFFFF_FFFF, 1);
      wr_en = 2'b01; wr_addr = {5'd0, 5'(16 + i)}; wr_data = {32'h0, d};
      rd_addr = {5'(16 + i), 5'd0};
      @(negedge clk);
      push_exp(64'(d)); chk("rand_bypass", 64'(rd_data[63:32]));
      push_exp(64'h0);  chk("rand_nb_old", 64'(nb_rd_data[63:32]));
      next_cycle(); idle();
      @(negedge clk);
      push_exp(64'(d)); chk("rand_nb_new", 64'(nb_rd_data[63:32]));
      next_cycle();
    end

    // Wide configuration sweep
    w_wr_en = 2'b11; w_wr_addr = {4'd2, 4'd1};
    w_wr_data = {64'hFEDCBA9876543210, 64'h0123456789ABCDEF};
    next_cycle();
    w_wr_en = 2'b11; w_wr_addr = {4'd0, 4'd15};
    w_wr_data = {64'hFFFFFFFFFFFFFFFF, 64'hA5A55A5A0F0FF0F0};
    next_cycle(); idle();
    w_rd_addr = {4'd0, 4'd15, 4'd2, 4'd1};
    @(negedge clk);
    push_exp(64'h0123456789ABCDEF); chk("wide_r1", w_rd_data[63:0]);
    push_exp(64'hFEDCBA9876543210); chk("wide_r2", w_rd_data[127:64]);
    push_exp(64'hA5A55A5A0F0FF0F0); chk("wide_r15", w_rd_data[191:128]);
    push_exp(64'h0);                chk("wide_r0", w_rd_data[255:192]);
    push_exp(64'hF);                chk("wide_ready", 64'(w_rd_ready));
    next_cycle();
    w_mark_en = 1'b1; w_mark_addr = 4'd15;
    next_cycle(); idle();
    @(negedge clk);
    push_exp(64'hB);    chk("wide_mark_ready", 64'(w_rd_ready));
    push_exp(64'h8000); chk("wide_busy", 64'(w_busy));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the next-generation datapath: configurable data width, depth and read-port count, two prioritised write ports, optional same-cycle write-to-read bypass, and a per-register scoreboard. The scoreboard tracks pending writes so the pipeline can stall on read-after-write hazards. It replaces the single-write, two-read, 32x32 file in the decode/write-back stage. Register 0 is hardwired to zero.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = a read of a register being written this cycle returns the write data; 0 = returns the stored value
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, same packing as rd_addr
- rd_ready  out  NUM_RD  1 = addressed register has no pending write (always 1 for register 0)
- wr_en  in  2  write enables for ports 0 and 1 (write-back lanes)
- wr_addr  in  2*ADDR_W  write addresses
- wr_data  in  2*DATA_W  write data
- mark_en  in  1  reserve a destination register: set its busy bit
- mark_addr  in  ADDR_W  register to reserve
- busy  out  2**ADDR_W  scoreboard vector; bit 0 is constant 0

## Operation
- Storage: 2**ADDR_W entries of DATA_W bits. Entry 0 reads as 0 at all times. Writes to address 0 are discarded and have no scoreboard effect.
- Write: for each port with wr_en=1 and a nonzero address, the entry takes wr_data at the rising edge.
- Same-address double write: port 1 wins and port 0 is dropped. This is not an error.
- Read is combinational: rd_data[k] = entry[rd_addr[k]].
- Bypass (BYPASS=1): if a write port targets rd_addr[k] (nonzero) in the current cycle, rd_data[k] = that port's wr_data, with port 1 taking priority. rd_ready[k] is then 1 for that cycle.
- Scoreboard, one busy bit per register:
  - mark_en with a nonzero address sets the bit at the next edge.
  - A write with a nonzero address clears the bit at the next edge.
  - Mark and write to the same address in the same cycle: busy stays 1. The new producer wins; the write still commits its data.
  - Marking an already-busy register: bit stays 1 (no counting).
  - A write to a non-busy register: data commits, bit stays 0.
- rd_ready[k] = ~busy[rd_addr[k]], ORed with the bypass hit when BYPASS=1.

## Timing
- Reset (rst_n=0, asynchronous):
  - All entries go to 0 and all busy bits go to 0.
  - rd_data = 0 and rd_ready = all 1s immediately, without waiting for a clock.
  - Writes and marks presented during reset are ignored.
- Reset deasserts asynchronously. The first state update is at the first rising edge with rst_n=1.
- Read latency is 0 cycles; read-after-write through storage is 1 cycle, or 0 with bypass.
- Busy set by a mark is visible on busy/rd_ready the cycle after mark_en. A clear is visible the cycle after wr_en.
- No handshakes. Every input is sampled each cycle, and the caller is responsible for stalling on rd_ready=0.

## Structure
- Shared package regfile_pkg: default DATA_W/ADDR_W/NUM_RD constants, the ZERO_REG address constant, and a function extracting field k from a packed port vector.
- One sub-module, regfile_scoreboard (ADDR_W parameter): holds the busy vector and the mark/clear priority logic, plus the async reset.
- The top level holds storage, the write-priority mux, and the per-port generate loop with bypass.

## Test plan
- Reset mid-operation: write 0xDEADBEEF to r5 and mark r7, then pulse rst_n low between edges -> rd_data for r5 = 0 immediately, busy = 0, rd_ready all 1.
- Double write: port 0 writes r3=0x11 and port 1 writes r3=0x22 in the same cycle -> r3 reads 0x22 next cycle, and 0x22 same cycle with BYPASS=1.
- Zero register: write 0xFFFFFFFF to r0 and mark r0 -> r0 reads 0, busy[0]=0, rd_ready=1.
- Scoreboard: mark r9, then read r9 next cycle -> rd_ready=0. Write r9=0x1234 one cycle later -> same-cycle rd_ready=1 and rd_data=0x1234 with BYPASS=1; with BYPASS=0, rd_ready=0 and old data that cycle, then 1 and 0x1234.
- Mark and clear collision: r4 busy, then mark r4 and write r4=0x55 in the same cycle -> r4 holds 0x55 and busy[4] stays 1.
- Configuration sweep: NUM_RD=4, DATA_W=64, ADDR_W=4 -> four independent reads of r1, r2, r15, r0 return their written 64-bit values and 0 respectively.
